// File: rtl/fft_ram_sequencer.sv
// Sequencer that owns the single-port FFT sample RAM and hands it to the AXI bridge
// or the FFT engine through a fixed LOAD -> START -> CALC -> UNLOAD cycle.
module fft_ram_sequencer #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 12,
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic [ADDR_WIDTH-1:0]   i_SAMPLES_NUMBER,
  input  logic                    i_ERR_CLR,
  input  logic                    i_BR_WRITE,
  input  logic                    i_BR_READ,
  input  logic [ADDR_WIDTH-1:0]   i_BR_INDEX,
  input  logic [SAMPLE_WIDTH-1:0] i_BR_SAMPLE,
  input  logic                    i_BR_DATA_LOADED,
  output logic [DATA_WIDTH-1:0]   o_BR_RDATA,
  output logic                    o_BR_CALC_END,
  output logic                    o_FFT_START,
  output logic [ADDR_WIDTH-1:0]   o_FFT_N,
  input  logic                    i_FFT_WE,
  input  logic                    i_FFT_RE,
  input  logic [ADDR_WIDTH-1:0]   i_FFT_ADDR,
  input  logic [DATA_WIDTH-1:0]   i_FFT_WDATA,
  input  logic                    i_FFT_DONE,
  output logic [DATA_WIDTH-1:0]   o_FFT_RDATA,
  output logic                    o_RAM_EN,
  output logic                    o_RAM_WE,
  output logic [ADDR_WIDTH-1:0]   o_RAM_ADDR,
  output logic [DATA_WIDTH-1:0]   o_RAM_WDATA,
  input  logic [DATA_WIDTH-1:0]   i_RAM_RDATA,
  output logic [1:0]              o_STATE,
  output logic                    o_ERR
);

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_START  = 2'd1,
    S_CALC   = 2'd2,
    S_UNLOAD = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                  r_state, w_state_next;
  logic [ADDR_WIDTH-1:0]   r_fft_n, w_fft_n_next;
  logic [ADDR_WIDTH-1:0]   r_cnt, w_cnt_next;
  logic                    r_err;
  logic                    w_err_set;
  logic                    w_fft_start;
  logic                    w_n_legal;
  logic                    w_ram_en, w_ram_we;
  logic [ADDR_WIDTH-1:0]   w_ram_addr;
  logic [DATA_WIDTH-1:0]   w_ram_wdata;
  logic [DATA_WIDTH-1:0]   w_br_word;
  logic                    w_br_any, w_fft_any;

  // Bridge samples are real-only: imaginary half of the complex word is zero.
  assign w_br_word = {i_BR_SAMPLE, {(DATA_WIDTH-SAMPLE_WIDTH){1'b0}}};
  assign w_br_any  = i_BR_WRITE | i_BR_READ;
  assign w_fft_any = i_FFT_WE | i_FFT_RE;

  // A legal size is a single set bit anywhere except bit 0 (N = 2 .. 2^(ADDR_WIDTH-1)).
  assign w_n_legal = (r_fft_n != '0) && ((r_fft_n & (r_fft_n - ONE)) == '0) && !r_fft_n[0];

  // NOTE: every combinational output gets a default before the case so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_fft_n_next = r_fft_n;
    w_cnt_next   = r_cnt;
    w_err_set    = 1'b0;
    w_fft_start  = 1'b0;
    w_ram_en     = 1'b0;
    w_ram_we     = 1'b0;
    w_ram_addr   = i_BR_INDEX;
    w_ram_wdata  = w_br_word;
    case (r_state)
      S_LOAD: begin
        if (i_BR_WRITE) begin
          w_ram_en = 1'b1;
          w_ram_we = 1'b1;
        end
        if (i_BR_READ || w_fft_any) w_err_set = 1'b1;
        if (i_BR_DATA_LOADED) begin
          w_fft_n_next = i_SAMPLES_NUMBER;
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (w_br_any || w_fft_any) w_err_set = 1'b1;
        if (w_n_legal) begin
          w_fft_start  = 1'b1;
          w_state_next = S_CALC;
        end else begin
          w_err_set    = 1'b1;
          w_state_next = S_LOAD;
        end
      end
      S_CALC: begin
        w_ram_addr  = i_FFT_ADDR;
        w_ram_wdata = i_FFT_WDATA;
        w_ram_en    = w_fft_any;
        w_ram_we    = i_FFT_WE;
        if (w_br_any) w_err_set = 1'b1;
        if (i_FFT_DONE) w_state_next = S_UNLOAD;
      end
      S_UNLOAD: begin
        if (i_BR_WRITE || w_fft_any) w_err_set = 1'b1;
        if (i_BR_READ) begin
          if (i_BR_INDEX >= r_fft_n) begin
            w_err_set = 1'b1;
          end else begin
            w_ram_en = 1'b1;
            // The read that completes the drain returns the RAM to the bridge for loading.
            if ((r_cnt + ONE) == r_fft_n) begin
              w_cnt_next   = '0;
              w_state_next = S_LOAD;
            end else begin
              w_cnt_next = r_cnt + ONE;
            end
          end
        end
      end
      default: w_state_next = S_LOAD;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of block ordering.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= S_LOAD;
      r_fft_n <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_fft_n <= w_fft_n_next;
      r_cnt   <= w_cnt_next;
      if (w_err_set)      r_err <= 1'b1;
      else if (i_ERR_CLR) r_err <= 1'b0;
    end
  end

  // RAM strobes are gated by reset directly so nothing reaches the RAM while held in reset.
  assign o_RAM_EN      = w_ram_en & i_rstn;
  assign o_RAM_WE      = w_ram_we & i_rstn;
  assign o_RAM_ADDR    = w_ram_addr;
  assign o_RAM_WDATA   = w_ram_wdata;
  assign o_BR_RDATA    = i_RAM_RDATA;
  assign o_FFT_RDATA   = i_RAM_RDATA;
  assign o_FFT_START   = w_fft_start;
  assign o_FFT_N       = r_fft_n;
  assign o_BR_CALC_END = (r_state == S_UNLOAD);
  assign o_STATE       = r_state;
  assign o_ERR         = r_err;

endmodule

// File: tb/tb_fft_ram_sequencer.sv
// Self-checking bench for fft_ram_sequencer: directed LOAD/START/CALC/UNLOAD passes,
// illegal accesses, mid-operation resets and randomized passes against a RAM-content model.
module tb_fft_ram_sequencer;
  localparam int DW = 32;
  localparam int AW = 12;
  localparam int SW = 16;

  logic          i_clk = 1'b0;
  logic          i_rstn;
  logic [AW-1:0] i_SAMPLES_NUMBER;
  logic          i_ERR_CLR;
  logic          i_BR_WRITE, i_BR_READ;
  logic [AW-1:0] i_BR_INDEX;
  logic [SW-1:0] i_BR_SAMPLE;
  logic          i_BR_DATA_LOADED;
  logic [DW-1:0] o_BR_RDATA;
  logic          o_BR_CALC_END;
  logic          o_FFT_START;
  logic [AW-1:0] o_FFT_N;
  logic          i_FFT_WE, i_FFT_RE;
  logic [AW-1:0] i_FFT_ADDR;
  logic [DW-1:0] i_FFT_WDATA;
  logic          i_FFT_DONE;
  logic [DW-1:0] o_FFT_RDATA;
  logic          o_RAM_EN, o_RAM_WE;
  logic [AW-1:0] o_RAM_ADDR;
  logic [DW-1:0] o_RAM_WDATA;
  logic [DW-1:0] i_RAM_RDATA;
  logic [1:0]    o_STATE;
  logic          o_ERR;

  int n_vec = 0;
  int n_err = 0;
  int start_cnt = 0;

  logic [DW-1:0] mem     [0:4095];
  logic [DW-1:0] ref_mem [0:4095];

  always #5 i_clk = ~i_clk;

  fft_ram_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SAMPLE_WIDTH(SW)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_SAMPLES_NUMBER(i_SAMPLES_NUMBER), .i_ERR_CLR(i_ERR_CLR),
    .i_BR_WRITE(i_BR_WRITE), .i_BR_READ(i_BR_READ), .i_BR_INDEX(i_BR_INDEX),
    .i_BR_SAMPLE(i_BR_SAMPLE), .i_BR_DATA_LOADED(i_BR_DATA_LOADED), .o_BR_RDATA(o_BR_RDATA),
    .o_BR_CALC_END(o_BR_CALC_END), .o_FFT_START(o_FFT_START), .o_FFT_N(o_FFT_N),
    .i_FFT_WE(i_FFT_WE), .i_FFT_RE(i_FFT_RE), .i_FFT_ADDR(i_FFT_ADDR), .i_FFT_WDATA(i_FFT_WDATA),
    .i_FFT_DONE(i_FFT_DONE), .o_FFT_RDATA(o_FFT_RDATA), .o_RAM_EN(o_RAM_EN), .o_RAM_WE(o_RAM_WE),
    .o_RAM_ADDR(o_RAM_ADDR), .o_RAM_WDATA(o_RAM_WDATA), .i_RAM_RDATA(i_RAM_RDATA),
    .o_STATE(o_STATE), .o_ERR(o_ERR)
  );

  // Single-port RAM with one cycle of read latency.
  always @(posedge i_clk) begin
    if (o_RAM_EN) begin
      if (o_RAM_WE) mem[o_RAM_ADDR] <= o_RAM_WDATA;
      i_RAM_RDATA <= mem[o_RAM_ADDR];
    end
  end

  always @(negedge i_clk) if (o_FFT_START === 1'b1) start_cnt <= start_cnt + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, vectors=%0d miscompares=%0d", n_vec, n_err);
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit legal_n(input int n);
    for (int i = 1; i <= 11; i++) if (n == (1 << i)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic idle();
    i_BR_WRITE = 0; i_BR_READ = 0; i_BR_DATA_LOADED = 0; i_ERR_CLR = 0;
    i_FFT_WE = 0; i_FFT_RE = 0; i_FFT_DONE = 0;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_err();
    idle(); i_ERR_CLR = 1; tick(); idle();
    check("err_clr", 32'(o_ERR), 32'd0);
  endtask

  task automatic do_load(input int n, input bit directed);
    logic [SW-1:0] s;
    for (int k = 0; k < n; k++) begin
      s = directed ? 16'(k + 1) : 16'($urandom);
      idle();
      i_BR_WRITE = 1; i_BR_INDEX = 12'(k); i_BR_SAMPLE = s;
      if (k == n - 1) begin
        i_BR_DATA_LOADED = 1; i_SAMPLES_NUMBER = 12'(n);
      end
      #1;
      if (k == 0 || k == n - 1) begin
        check("load_ram_en", 32'({o_RAM_EN, o_RAM_WE}), 32'd3);
        check("load_wdata", o_RAM_WDATA, {s, 16'h0000});
      end
      tick();
      ref_mem[k] = {s, 16'h0000};
    end
    idle();
    check("start_state", 32'(o_STATE), 32'd1);
    check("start_pulse", 32'(o_FFT_START), 32'd1);
    check("start_fft_n", 32'(o_FFT_N), 32'(n));
    tick();
    check("calc_state", 32'(o_STATE), 32'd2);
    check("calc_no_pulse", 32'(o_FFT_START), 32'd0);
  endtask

  task automatic do_calc(input int n, input bit directed, input bit inject);
    logic [DW-1:0] w;
    if (inject) begin
      idle(); i_BR_WRITE = 1; i_BR_INDEX = 12'd0; i_BR_SAMPLE = 16'hDEAD; #1;
      check("calc_br_wr_blocked", 32'(o_RAM_EN), 32'd0);
      tick(); idle();
      check("calc_br_wr_err", 32'(o_ERR), 32'd1);
      check("calc_br_wr_mem", mem[0], ref_mem[0]);
      clear_err();
    end
    for (int k = 0; k < n; k++) begin
      idle(); i_FFT_RE = 1; i_FFT_ADDR = 12'(k); tick(); idle();
      check("eng_rdata", o_FFT_RDATA, ref_mem[k]);
    end
    for (int k = 0; k < n; k++) begin
      w = directed ? (32'hA000_0000 | 32'(k)) : $urandom;
      idle(); i_FFT_WE = 1; i_FFT_ADDR = 12'(k); i_FFT_WDATA = w;
      if (k == n - 1) i_FFT_DONE = 1;
      #1;
      if (k == n - 1) begin
        check("eng_wr_en", 32'({o_RAM_EN, o_RAM_WE}), 32'd3);
        check("done_cycle_calc_end", 32'(o_BR_CALC_END), 32'd0);
      end
      tick();
      ref_mem[k] = w;
    end
    idle();
    check("unload_state", 32'(o_STATE), 32'd3);
    check("unload_calc_end", 32'(o_BR_CALC_END), 32'd1);
  endtask

  task automatic br_read(input int k, input bit last);
    idle(); i_BR_READ = 1; i_BR_INDEX = 12'(k); #1;
    check("unload_rd_en", 32'(o_RAM_EN), 32'd1);
    tick(); idle();
    check("unload_rdata", o_BR_RDATA, ref_mem[k]);
    check("unload_rd_state", 32'(o_STATE), last ? 32'd0 : 32'd3);
    check("unload_rd_calc_end", 32'(o_BR_CALC_END), last ? 32'd0 : 32'd1);
  endtask

  task automatic run_pass(input int n, input bit directed, input bit inject);
    int s0;
    s0 = start_cnt;
    do_load(n, directed);
    do_calc(n, directed, inject);
    for (int k = 0; k < n; k++) begin
      if (inject && k == 3) begin
        idle(); i_BR_READ = 1; i_BR_INDEX = 12'(n + 1); #1;
        check("unload_oob_blocked", 32'(o_RAM_EN), 32'd0);
        tick(); idle();
        check("unload_oob_err", 32'(o_ERR), 32'd1);
        check("unload_oob_state", 32'(o_STATE), 32'd3);
        clear_err();
      end
      br_read(k, k == n - 1);
    end
    check("pass_start_once", 32'(start_cnt - s0), 32'd1);
    check("pass_err", 32'(o_ERR), 32'd0);
  endtask

  task automatic bad_n(input int n);
    int s0;
    s0 = start_cnt;
    idle(); i_BR_DATA_LOADED = 1; i_SAMPLES_NUMBER = 12'(n); tick(); idle();
    check("badn_start_state", 32'(o_STATE), 32'd1);
    check("badn_no_pulse", 32'(o_FFT_START), 32'd0);
    tick();
    check("badn_back_to_load", 32'(o_STATE), 32'd0);
    check("badn_err", 32'(o_ERR), 32'd1);
    check("badn_pulse_count", 32'(start_cnt - s0), 32'd0);
    clear_err();
  endtask

  task automatic async_reset();
    #2; i_rstn = 0; #1;
    check("mid_rst_state", 32'(o_STATE), 32'd0);
    check("mid_rst_fft_n", 32'(o_FFT_N), 32'd0);
    check("mid_rst_calc_end", 32'(o_BR_CALC_END), 32'd0);
    check("mid_rst_start", 32'(o_FFT_START), 32'd0);
    check("mid_rst_ram_en", 32'(o_RAM_EN), 32'd0);
    idle(); #2; i_rstn = 1;
    tick();
  endtask

  initial begin
    int n;
    for (int i = 0; i < 4096; i++) ref_mem[i] = '0;
    i_rstn = 0; idle();
    i_SAMPLES_NUMBER = '0; i_BR_INDEX = '0; i_BR_SAMPLE = '0; i_FFT_ADDR = '0; i_FFT_WDATA = '0;
    i_BR_WRITE = 1;
    #2;
    check("rst_state", 32'(o_STATE), 32'd0);
    check("rst_start", 32'(o_FFT_START), 32'd0);
    check("rst_fft_n", 32'(o_FFT_N), 32'd0);
    check("rst_calc_end", 32'(o_BR_CALC_END), 32'd0);
    check("rst_err", 32'(o_ERR), 32'd0);
    check("rst_ram_en_we", 32'({o_RAM_EN, o_RAM_WE}), 32'd0);
    #10; idle();
    @(negedge i_clk); i_rstn = 1;
    tick();

    // Directed N=8 pass: samples k+1, engine results A000_000k.
    run_pass(8, 1'b1, 1'b0);

    bad_n(12);

    idle(); i_FFT_RE = 1; i_FFT_ADDR = 12'd3; #1;
    check("eng_rd_load_blocked", 32'(o_RAM_EN), 32'd0);
    tick(); idle();
    check("eng_rd_load_err", 32'(o_ERR), 32'd1);
    clear_err();

    idle(); i_BR_WRITE = 1; i_BR_READ = 1; i_BR_INDEX = 12'd20; i_BR_SAMPLE = 16'h1234; #1;
    check("wr_rd_load_en", 32'({o_RAM_EN, o_RAM_WE}), 32'd3);
    tick(); idle();
    ref_mem[20] = 32'h1234_0000;
    check("wr_rd_load_err", 32'(o_ERR), 32'd1);
    check("wr_rd_load_mem", mem[20], ref_mem[20]);
    clear_err();

    idle(); i_ERR_CLR = 1; i_BR_READ = 1; tick(); idle();
    check("set_beats_clr", 32'(o_ERR), 32'd1);
    clear_err();

    run_pass(8, 1'b0, 1'b1);

    // Reset while the engine owns the RAM, with an engine write pending.
    do_load(8, 1'b0);
    i_FFT_WE = 1; i_FFT_ADDR = 12'd2; i_FFT_WDATA = 32'hBAD0_BAD0;
    async_reset();
    check("rst_calc_mem_kept", mem[2], ref_mem[2]);

    // Reset part-way through draining, then a fresh N=4 pass.
    do_load(8, 1'b0);
    do_calc(8, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) br_read(k, 1'b0);
    async_reset();
    run_pass(4, 1'b0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      n = int'($urandom_range(0, 40));
      if (legal_n(n)) run_pass(n, 1'b0, 1'b0);
      else bad_n(n);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fft_ram_sequencer.md
# fft_ram_sequencer

Owns the single-port FFT sample RAM and shares it between the AXI bridge and the FFT engine in a fixed LOAD -> START -> CALC -> UNLOAD cycle. It hands RAM ownership to the bridge while samples are loaded and drained, and to the engine during computation. It issues the engine start pulse with a latched transform size, returns calc-end to the bridge, and flags illegal accesses.

## Interface
- DATA_WIDTH, 32, RAM word width (complex word: real [31:16], imag [15:0])
- ADDR_WIDTH, 12, RAM index width
- SAMPLE_WIDTH, 16, bridge sample width
- i_clk  in  1  clock, all state on rising edge
- i_rstn  in  1  reset, asynchronous, active-low
- i_SAMPLES_NUMBER  in  ADDR_WIDTH  requested transform size N
- i_ERR_CLR  in  1  synchronous clear of o_ERR
- i_BR_WRITE, i_BR_READ  in  1  bridge RAM write / read strobe
- i_BR_INDEX  in  ADDR_WIDTH  bridge sample index
- i_BR_SAMPLE  in  SAMPLE_WIDTH  bridge write sample (real part)
- i_BR_DATA_LOADED  in  1  bridge finished loading
- o_BR_RDATA  out  DATA_WIDTH  read data to bridge
- o_BR_CALC_END  out  1  results ready for unload
- o_FFT_START  out  1  one-cycle start pulse
- o_FFT_N  out  ADDR_WIDTH  latched transform size
- i_FFT_WE, i_FFT_RE  in  1  engine write / read strobe
- i_FFT_ADDR  in  ADDR_WIDTH  engine index
- i_FFT_WDATA  in  DATA_WIDTH  engine write data
- i_FFT_DONE  in  1  engine finished
- o_FFT_RDATA  out  DATA_WIDTH  read data to engine
- o_RAM_EN, o_RAM_WE  out  1  RAM enable / write enable
- o_RAM_ADDR  out  ADDR_WIDTH  RAM index
- o_RAM_WDATA  out  DATA_WIDTH  RAM write data
- i_RAM_RDATA  in  DATA_WIDTH  RAM read data, 1-cycle latency
- o_STATE  out  2  LOAD=0, START=1, CALC=2, UNLOAD=3
- o_ERR  out  1  sticky illegal-access / illegal-size flag

## Operation
- Reset: state LOAD; o_FFT_START=0, o_FFT_N=0, o_BR_CALC_END=0, o_ERR=0, unload counter 0. o_RAM_EN and o_RAM_WE are forced 0 while i_rstn is low.
- LOAD: the bridge owns the RAM. Only i_BR_WRITE is legal.
  - Write: o_RAM_EN=o_RAM_WE=1, o_RAM_ADDR=i_BR_INDEX, o_RAM_WDATA={i_BR_SAMPLE,16'h0}.
  - i_BR_DATA_LOADED: latch o_FFT_N<=i_SAMPLES_NUMBER and go to START. A write in the same cycle is still performed.
- START: check N. Legal N means exactly one bit set at position 1..11 (2..2048).
  - Legal N: o_FFT_START=1 for this cycle, go to CALC.
  - Illegal N: set o_ERR, no pulse, go to LOAD.
  - No RAM access is legal in START.
- CALC: the engine owns the RAM.
  - Addressing: o_RAM_ADDR=i_FFT_ADDR, o_RAM_WDATA=i_FFT_WDATA.
  - Strobes: o_RAM_EN=i_FFT_WE|i_FFT_RE, o_RAM_WE=i_FFT_WE.
  - i_FFT_DONE: go to UNLOAD. An access in the same cycle is still performed.
- UNLOAD: the bridge owns the RAM. Only i_BR_READ is legal.
  - o_BR_CALC_END=1 throughout UNLOAD.
  - Each read increments the unload counter.
  - The read that brings the counter to o_FFT_N moves the state to LOAD and clears the counter.
- Illegal access: an engine strobe outside CALC, a bridge strobe not permitted in the current state, or any bridge index >= o_FFT_N in UNLOAD.
  - The access is blocked: o_RAM_EN=0, and it does not count.
  - o_ERR is set.
  - o_ERR is cleared only by i_ERR_CLR or reset. A set in the same cycle as i_ERR_CLR wins.
- Simultaneous i_BR_WRITE and i_BR_READ in LOAD: the write proceeds and o_ERR is set.
- o_BR_RDATA and o_FFT_RDATA both carry i_RAM_RDATA unmodified.

## Timing
- RAM mux, enables and o_STATE are combinational from the state register. The sequencer adds zero latency; a request reaches the RAM in its own cycle.
- Read data is valid on o_BR_RDATA / o_FFT_RDATA one cycle after the strobe (the RAM latency).
- The last UNLOAD read is issued in UNLOAD. Its data appears in the following cycle, when the state is already LOAD.
- From the i_BR_DATA_LOADED cycle: START in the next cycle, o_FFT_START high for that one cycle, CALC in the cycle after.
- From the i_FFT_DONE cycle: UNLOAD and o_BR_CALC_END=1 in the next cycle.
- Reset mid-operation (any state): return to LOAD immediately (asynchronous). All registered outputs go to their reset values; a pending START pulse is cancelled.

## Test plan
- N=8 full pass: 8 bridge writes with sample k+1 to indices 0..7, DATA_LOADED, engine writes 32'hA000_000k, DONE, 8 reads.
  - o_FFT_START pulses once with o_FFT_N=8.
  - Reads return A000_0000..A000_0007.
  - State returns to LOAD after the 8th read; o_ERR=0.
- Illegal N=12: DATA_LOADED -> START.
  - No o_FFT_START; o_ERR=1; state LOAD two cycles after DATA_LOADED.
- Illegal accesses:
  - Bridge write in CALC: o_RAM_EN=0, o_ERR=1, no RAM change.
  - Engine read in LOAD: o_ERR=1.
  - Bridge read of index 9 with N=8 in UNLOAD: blocked, unload counter unchanged.
  - i_ERR_CLR clears o_ERR on the next edge.
- Simultaneous events:
  - Write with DATA_LOADED: the write lands.
  - Engine write with DONE: the write lands.
  - o_BR_CALC_END rises exactly one cycle after DONE.
- Reset asserted in CALC and in UNLOAD after 3 of 8 reads:
  - State LOAD, o_FFT_N=0, o_BR_CALC_END=0.
  - A new N=4 pass completes after exactly 4 reads.
